// File: rtl/bcd_gray_pkg.sv
// Shared types and constants for the serial BCD to binary/Gray converter.
// Holds the FSM state encoding, result mode codes and the width check.
package bcd_gray_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic MODE_GRAY = 1'b0;
    localparam logic MODE_BIN  = 1'b1;

    // Bits needed to hold any value below 10**digits.
    function automatic int min_out_w(input int digits);
        int p;
        p = 1;
        for (int i = 0; i < digits; i++) begin
            p = p * 10;
        end
        return $clog2(p);
    endfunction

endpackage

// File: rtl/gray_encode.sv
// Binary to reflected Gray code mapping.
// Purely combinational.
module gray_encode #(
    parameter int W = 14
) (
    input  logic [W-1:0] b,
    output logic [W-1:0] g
);

    assign g = b ^ (b >> 1);

endmodule

// File: rtl/bcd_gray_serial.sv
// Serial packed-BCD to binary/Gray converter, one digit per clock.
// Valid/ready on both sides; result held until the consumer takes it.
module bcd_gray_serial #(
    parameter int DIGITS = 4,
    parameter int OUT_W  = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   in_bcd,
    input  logic                  in_mode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_W-1:0]      out_data,
    output logic                  out_err
);

    import bcd_gray_pkg::*;

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
        $error("bcd_gray_serial: DIGITS must be 1..8");
    end

    if (OUT_W < min_out_w(DIGITS)) begin : g_bad_width
        $error("bcd_gray_serial: OUT_W too small for DIGITS");
    end

    state_t               state_q;
    state_t               state_d;
    logic [4*DIGITS-1:0]  bcd_q;
    logic                 mode_q;
    logic [OUT_W-1:0]     acc_q;
    logic                 err_q;
    logic [IDX_W-1:0]     idx_q;
    logic [OUT_W-1:0]     out_data_q;
    logic                 out_err_q;

    logic [3:0]           digit;
    logic                 digit_bad;
    logic                 last;
    logic                 err_nxt;
    logic [OUT_W-1:0]     acc_nxt;
    logic [OUT_W-1:0]     gray_nxt;
    logic [OUT_W-1:0]     result;

    // Digit step: acc*10 + digit, error accumulation and final result select.
    always_comb begin
        digit     = bcd_q[{idx_q, 2'b00} +: 4];
        digit_bad = digit > 4'd9;
        last      = idx_q == '0;
        err_nxt   = err_q | digit_bad;
        acc_nxt   = (acc_q << 3) + (acc_q << 1) + OUT_W'(digit);
        if (err_nxt) begin
            result = '0;
        end else if (mode_q == MODE_GRAY) begin
            result = gray_nxt;
        end else begin
            result = acc_nxt;
        end
    end

    gray_encode #(
        .W (OUT_W)
    ) u_gray (
        .b (acc_nxt),
        .g (gray_nxt)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: accept, convert DIGITS cycles, hold until taken.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (in_valid)  state_d = CONV;
            CONV: if (last)      state_d = HOLD;
            HOLD: if (out_ready) state_d = IDLE;
            default:             state_d = IDLE;
        endcase
    end

    // Handshake outputs decoded from state.
    always_comb begin
        in_ready  = state_q == IDLE;
        out_valid = state_q == HOLD;
        out_data  = out_data_q;
        out_err   = out_err_q;
    end

    // Datapath: latch word on accept, step one digit per CONV cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            bcd_q      <= '0;
            mode_q     <= MODE_GRAY;
            acc_q      <= '0;
            err_q      <= 1'b0;
            idx_q      <= '0;
            out_data_q <= '0;
            out_err_q  <= 1'b0;
        end else if (state_q == IDLE && in_valid) begin
            bcd_q  <= in_bcd;
            mode_q <= in_mode;
            acc_q  <= '0;
            err_q  <= 1'b0;
            idx_q  <= IDX_W'(DIGITS - 1);
        end else if (state_q == CONV) begin
            acc_q <= acc_nxt;
            err_q <= err_nxt;
            idx_q <= idx_q - 1'b1;
            if (last) begin
                out_data_q <= result;
                out_err_q  <= err_nxt;
            end
        end
    end

endmodule

// File: tb/tb_bcd_gray_serial.sv
// Directed bench for bcd_gray_serial at DIGITS=4, OUT_W=14.
// Each scenario task compares against hand-computed values.
module tb_bcd_gray_serial;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_bcd;
    logic        in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [13:0] out_data;
    logic        out_err;

    int tests;
    int fails;

    bcd_gray_serial #(
        .DIGITS (4),
        .OUT_W  (14)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bcd    (in_bcd),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Accept one word, scramble inputs during conversion, measure latency
    // (accepting edge counted as edge 1), capture result, then take it.
    task automatic send_word(input logic [15:0] bcd, input logic mode,
                             output int lat, output logic [13:0] d,
                             output logic e);
        lat = -1;
        d   = '0;
        e   = 1'b0;
        @(negedge clk);
        in_bcd   = bcd;
        in_mode  = mode;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_bcd   = 16'hFFFF;
        in_mode  = ~mode;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = k + 1;
                break;
            end
        end
        if (lat > 0) begin
            d = out_data;
            e = out_err;
            @(negedge clk);
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if ({in_ready, out_valid, out_err, out_data} !== {1'b1, 1'b0, 1'b0, 14'h0}) begin
            fails++;
            $display("FAIL reset: rdy=%b vld=%b err=%b data=%h, want 1 0 0 0000",
                     in_ready, out_valid, out_err, out_data);
        end
        rst = 1'b0;
    endtask

    task automatic test_gray();
        logic [15:0] vin [3];
        logic [13:0] vexp [3];
        int lat;
        logic [13:0] d;
        logic e;
        vin[0] = 16'h0009; vexp[0] = 14'h000D;
        vin[1] = 16'h9999; vexp[1] = 14'h3488;
        vin[2] = 16'h0000; vexp[2] = 14'h0000;
        for (int i = 0; i < 3; i++) begin
            send_word(vin[i], 1'b0, lat, d, e);
            tests++;
            if (lat !== 5) begin
                fails++;
                $display("FAIL gray_lat %h: got %0d want 5", vin[i], lat);
            end
            tests++;
            if (d !== vexp[i]) begin
                fails++;
                $display("FAIL gray_data %h: got %h want %h", vin[i], d, vexp[i]);
            end
            tests++;
            if (e !== 1'b0) begin
                fails++;
                $display("FAIL gray_err %h: got %b want 0", vin[i], e);
            end
        end
    endtask

    task automatic test_binary();
        int lat;
        logic [13:0] d;
        logic e;
        send_word(16'h1234, 1'b1, lat, d, e);
        tests++;
        if ({d, e} !== {14'h04D2, 1'b0} || lat !== 5) begin
            fails++;
            $display("FAIL bin_1234: data=%h err=%b lat=%0d want 04d2 0 5", d, e, lat);
        end
        send_word(16'h1234, 1'b0, lat, d, e);
        tests++;
        if ({d, e} !== {14'h06BB, 1'b0} || lat !== 5) begin
            fails++;
            $display("FAIL gray_1234: data=%h err=%b lat=%0d want 06bb 0 5", d, e, lat);
        end
    endtask

    task automatic test_invalid();
        int lat;
        logic [13:0] d;
        logic e;
        for (int m = 0; m < 2; m++) begin
            send_word(16'h12A4, m[0], lat, d, e);
            tests++;
            if ({d, e} !== {14'h0000, 1'b1} || lat !== 5) begin
                fails++;
                $display("FAIL invalid mode%0d: data=%h err=%b lat=%0d want 0000 1 5",
                         m, d, e, lat);
            end
        end
    endtask

    task automatic test_reset_mid_conv();
        int seen;
        @(negedge clk);
        in_bcd   = 16'h1234;
        in_mode  = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        tests++;
        if ({in_ready, out_valid, out_err, out_data} !== {1'b1, 1'b0, 1'b0, 14'h0}) begin
            fails++;
            $display("FAIL rst_mid: rdy=%b vld=%b err=%b data=%h want 1 0 0 0000",
                     in_ready, out_valid, out_err, out_data);
        end
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        tests++;
        if (seen !== 0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL rst_mid_quiet: valid cycles=%0d rdy=%b want 0 1", seen, in_ready);
        end
    endtask

    task automatic test_backpressure();
        int got;
        int seen;
        @(negedge clk);
        in_bcd   = 16'h1234;
        in_mode  = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        got = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                got = 1;
                break;
            end
        end
        tests++;
        if (got !== 1) begin
            fails++;
            $display("FAIL bp_valid: out_valid timeout got %0d want 1", got);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            in_valid = i[0];
            in_bcd   = 16'h9999;
            in_mode  = 1'b0;
            tests++;
            if ({out_valid, in_ready, out_err, out_data} !== {1'b1, 1'b0, 1'b0, 14'h04D2}) begin
                fails++;
                $display("FAIL bp_hold%0d: vld=%b rdy=%b err=%b data=%h want 1 0 0 04d2",
                         i, out_valid, in_ready, out_err, out_data);
            end
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        tests++;
        if ({out_valid, in_ready} !== 2'b01) begin
            fails++;
            $display("FAIL bp_release: vld=%b rdy=%b want 0 1", out_valid, in_ready);
        end
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        tests++;
        if (seen !== 0) begin
            fails++;
            $display("FAIL bp_no_extra: valid cycles=%0d want 0", seen);
        end
    endtask

    task automatic test_back_to_back();
        logic [13:0] outs [2];
        int out_cyc [2];
        int acc_cyc [2];
        int nacc;
        int nout;
        logic acc_now;
        outs[0] = '0; outs[1] = '0;
        out_cyc[0] = 0; out_cyc[1] = 0;
        acc_cyc[0] = 0; acc_cyc[1] = 0;
        nacc = 0;
        nout = 0;
        @(negedge clk);
        in_bcd    = 16'h0001;
        in_mode   = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 60 && nout < 2; c++) begin
            if (c > 0) @(negedge clk);
            acc_now = in_valid && in_ready;
            if (out_valid) begin
                outs[nout]    = out_data;
                out_cyc[nout] = c;
                nout++;
            end
            if (acc_now && nacc < 2) begin
                acc_cyc[nacc] = c;
                nacc++;
            end
            @(posedge clk);
            #1;
            if (acc_now && nacc == 1) in_bcd = 16'h0002;
            if (acc_now && nacc == 2) in_valid = 1'b0;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tests++;
        if (nout !== 2 || nacc !== 2) begin
            fails++;
            $display("FAIL b2b_count: outs=%0d accepts=%0d want 2 2", nout, nacc);
        end
        tests++;
        if (outs[0] !== 14'h0001 || outs[1] !== 14'h0003) begin
            fails++;
            $display("FAIL b2b_data: got %h %h want 0001 0003", outs[0], outs[1]);
        end
        tests++;
        if (acc_cyc[1] - acc_cyc[0] !== 6) begin
            fails++;
            $display("FAIL b2b_in_period: got %0d want 6", acc_cyc[1] - acc_cyc[0]);
        end
        tests++;
        if (out_cyc[1] - out_cyc[0] !== 6) begin
            fails++;
            $display("FAIL b2b_out_period: got %0d want 6", out_cyc[1] - out_cyc[0]);
        end
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_bcd    = '0;
        in_mode   = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_gray();
        test_binary();
        test_invalid();
        test_reset_mid_conv();
        test_backpressure();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bcd_gray_serial.md
BCD_GRAY_SERIAL -- requirements
Module: bcd_gray_serial

Interface
REQ-001 Parameter DIGITS, default 4: number of packed BCD digits per input word, range 1..8.
REQ-002 Parameter OUT_W, default 14: result width; SHALL be at least ceil(log2(10^DIGITS)), elaboration error otherwise.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  input word present.
REQ-006 in_ready  output  1  block can accept a word.
REQ-007 in_bcd  input  4*DIGITS  packed BCD, most significant digit in MSBs.
REQ-008 in_mode  input  1  0 = Gray result, 1 = plain binary result.
REQ-009 out_valid  output  1  result present.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 out_data  output  OUT_W  converted value.
REQ-012 out_err  output  1  input contained a digit > 9.

Function
REQ-013 FSM states: IDLE, CONV, HOLD; in_ready SHALL be 1 only in IDLE.
REQ-014 Input handshake: in_valid && in_ready at an edge; in_bcd and in_mode latched, accumulator cleared, digit index = DIGITS-1, go to CONV.
REQ-015 CONV: one digit per cycle, MSD first; acc <= acc*10 + digit, in OUT_W bits; leaves after exactly DIGITS edges.
REQ-016 Any digit > 9 SHALL set a sticky error flag for the word; conversion still takes DIGITS cycles.
REQ-017 On the final CONV edge: out_data = 0 if error; else acc ^ (acc >> 1) if latched mode = 0; else acc; out_err = error flag; go to HOLD.
REQ-018 Latency: out_valid SHALL rise exactly DIGITS+1 edges after the accepting edge.
REQ-019 HOLD: out_valid = 1; out_data and out_err stable until out_valid && out_ready.
REQ-020 Output handshake returns FSM to IDLE; out_valid falls and in_ready rises in the next cycle; no overlap of input and output handshakes.
REQ-021 in_valid, in_bcd, in_mode changes while in CONV or HOLD SHALL be ignored.
REQ-022 out_ready is ignored while out_valid = 0; out_ready may be held high permanently.
REQ-023 in_mode is sampled only at the accepting edge; mid-conversion changes do not affect the result.

Reset
REQ-024 rst at an edge SHALL force IDLE: in_ready = 1, out_valid = 0, out_data = 0, out_err = 0, accumulator/error/index cleared.
REQ-025 rst overrides any simultaneous handshake; an in-flight word is discarded with no output.

Structure
REQ-026 Package bcd_gray_pkg SHALL hold the state enum (IDLE/CONV/HOLD), mode constants (MODE_GRAY = 0, MODE_BIN = 1) and the OUT_W minimum-width check constant function.
REQ-027 Sub-module gray_encode, combinational, parameter W: g = b ^ (b >> 1); instanced once on the result path.

Verification (DIGITS = 4, OUT_W = 14)
REQ-028 Reset mid-CONV: accept 0x1234, assert rst on the 2nd CONV edge -> IDLE next cycle, out_valid never asserted, in_ready = 1.
REQ-029 Gray mode: 0x0009 -> out_data 0x000D, out_err 0, out_valid exactly 5 edges after acceptance; 0x9999 -> 0x3488; 0x0000 -> 0x0000.
REQ-030 Binary mode: 0x1234 -> 0x04D2; Gray mode: 0x1234 -> 0x06BB.
REQ-031 Invalid digit: 0x12A4 in either mode -> out_err 1, out_data 0, same 5-edge latency.
REQ-032 Backpressure: out_ready low 6 cycles after out_valid -> out_data/out_err stable, in_ready 0, in_valid pulses ignored; out_ready high -> IDLE next cycle.
REQ-033 Throughput: in_valid and out_ready held high with words 0x0001, 0x0002 -> results 0x0001, 0x0003 in order, one word every 6 cycles.
